// File: rtl/vga_tile.sv
// vga_tile: parametrised VGA raster timing with an 8x8 two-plane tile renderer.
// Tiles come from external name/pattern RAMs; pixels go through a writable 64x12 palette.
module vga_tile #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter bit H_POL  = 1'b0,
  parameter bit V_POL  = 1'b0,
  parameter int NA_W   = 13
) (
  input  logic            CLOCK,
  input  logic            RESET,
  output logic [NA_W-1:0] NAME_ADDR,
  input  logic [11:0]     NAME_DATA,
  output logic [10:0]     PAT_ADDR,
  input  logic [15:0]     PAT_DATA,
  input  logic            PAL_WE,
  input  logic [5:0]      PAL_ADDR,
  input  logic [11:0]     PAL_DATA,
  output logic [3:0]      VGA_R,
  output logic [3:0]      VGA_G,
  output logic [3:0]      VGA_B,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            DE,
  output logic            FRAME
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int H_TILES = H_VIS / 8;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Raster counters
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic          h_wrap, v_wrap;

  // Fetch decode
  logic            fetch_wrap, fetch_col, fetch_go;
  logic [VW-1:0]   fetch_line;
  logic [NA_W-1:0] fetch_col_na, name_addr_d;

  // Fetch pipeline and pixel path
  logic [NA_W-1:0] name_addr_q;
  logic [10:0]     pat_addr_q;
  logic [3:0]      fetch_pipe_q;
  logic [2:0]      fetch_row_q;
  logic [3:0]      fetch_attr_q;
  logic [15:0]     stage_pat_q;
  logic [3:0]      stage_attr_q;
  logic [7:0]      sh0_q, sh1_q;
  logic [3:0]      attr_q;
  logic            pix_load;

  // Palette and registered outputs
  logic [11:0] pal_q [64];
  logic [5:0]  pix_idx;
  logic [11:0] rgb_d, rgb_q;
  logic        hs_d, vs_d, de_d, frame_d;
  logic        hs_q, vs_q, de_q, frame_q;

  always_comb begin
    h_wrap = (hc_q == HW'(H_TOTAL - 1));
    v_wrap = (vc_q == VW'(V_TOTAL - 1));
    hc_d   = h_wrap ? '0 : hc_q + HW'(1);
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    vc_d   = vc_q;
    if (h_wrap) vc_d = v_wrap ? '0 : vc_q + VW'(1);
  end

  // Column c is fetched at hc = 8c-8; column 0 is prefetched at the end of the previous line.
  always_comb begin
    fetch_wrap   = (hc_q == HW'(H_TOTAL - 8));
    fetch_col    = (hc_q[2:0] == 3'd0) && (hc_q < HW'(H_VIS - 8));
    fetch_line   = vc_q;
    fetch_col_na = NA_W'(hc_q >> 3) + NA_W'(1);
    if (fetch_wrap) begin
      fetch_line   = v_wrap ? '0 : vc_q + VW'(1);
      fetch_col_na = '0;
    end
    fetch_go    = (fetch_wrap || fetch_col) && (fetch_line < VW'(V_VIS));
    name_addr_d = NA_W'(fetch_line >> 3) * NA_W'(H_TILES) + fetch_col_na;
    pix_load    = h_wrap || ((hc_q[2:0] == 3'd7) && (hc_q < HW'(H_VIS - 8)));
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hc_q         <= '0;
      vc_q         <= '0;
      name_addr_q  <= '0;
      pat_addr_q   <= '0;
      fetch_pipe_q <= '0;
      fetch_row_q  <= '0;
      fetch_attr_q <= '0;
      stage_pat_q  <= '0;
      stage_attr_q <= '0;
      sh0_q        <= '0;
      sh1_q        <= '0;
      attr_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      fetch_pipe_q <= {fetch_pipe_q[2:0], fetch_go};
      if (fetch_go) begin
        name_addr_q <= name_addr_d;
        fetch_row_q <= fetch_line[2:0];
      end
      if (fetch_pipe_q[1]) begin
        pat_addr_q   <= {NAME_DATA[7:0], fetch_row_q};
        fetch_attr_q <= NAME_DATA[11:8];
      end
      if (fetch_pipe_q[3]) begin
        stage_pat_q  <= PAT_DATA;
        stage_attr_q <= fetch_attr_q;
      end
      if (pix_load) begin
        sh1_q  <= stage_pat_q[15:8];
        sh0_q  <= stage_pat_q[7:0];
        attr_q <= stage_attr_q;
      end else begin
        sh1_q <= {sh1_q[6:0], 1'b0};
        sh0_q <= {sh0_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      // NOTE: the palette is a register file, so it takes the reset like any other register.
      for (int i = 0; i < 64; i++) pal_q[i] <= '0;
    end else if (PAL_WE) begin
      pal_q[PAL_ADDR] <= PAL_DATA;
    end
  end

  always_comb begin
    pix_idx = {attr_q, sh1_q[7], sh0_q[7]};
    de_d    = (hc_q < HW'(H_VIS)) && (vc_q < VW'(V_VIS));
    rgb_d   = de_d ? pal_q[pix_idx] : 12'h000;
    hs_d    = ((hc_q >= HW'(H_VIS + H_FP)) && (hc_q < HW'(H_VIS + H_FP + H_SYNC))) ? H_POL : ~H_POL;
    vs_d    = ((vc_q >= VW'(V_VIS + V_FP)) && (vc_q < VW'(V_VIS + V_FP + V_SYNC))) ? V_POL : ~V_POL;
    frame_d = (hc_q == '0) && (vc_q == '0);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rgb_q   <= '0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      de_q    <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      frame_q <= frame_d;
    end
  end

  assign NAME_ADDR = name_addr_q;
  assign PAT_ADDR  = pat_addr_q;
  assign VGA_R     = rgb_q[11:8];
  assign VGA_G     = rgb_q[7:4];
  assign VGA_B     = rgb_q[3:0];
  assign VGA_HS    = hs_q;
  assign VGA_VS    = vs_q;
  assign DE        = de_q;
  assign FRAME     = frame_q;

endmodule

// File: tb/tb_vga_tile.sv
// tb_vga_tile: reduced-timing vga_tile run against a per-pixel picture model built from
// the raster rules, RAM contents and a shadow palette; random RAM and palette traffic.
module tb_vga_tile;

  localparam int H_VIS = 64, H_FP = 5, H_SYNC = 16, H_BP = 8;
  localparam int V_VIS = 32, V_FP = 2, V_SYNC = 2, V_BP = 4;
  localparam int NA_W  = 5;
  localparam int H_TOTAL   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME_CYC = H_TOTAL * V_TOTAL;
  localparam int HT        = H_VIS / 8;

  logic            CLOCK, RESET;
  logic [NA_W-1:0] NAME_ADDR;
  logic [11:0]     NAME_DATA;
  logic [10:0]     PAT_ADDR;
  logic [15:0]     PAT_DATA;
  logic            PAL_WE;
  logic [5:0]      PAL_ADDR;
  logic [11:0]     PAL_DATA;
  logic [3:0]      VGA_R, VGA_G, VGA_B;
  logic            VGA_HS, VGA_VS, DE, FRAME;

  vga_tile #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .H_POL(1'b0), .V_POL(1'b0), .NA_W(NA_W)
  ) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .NAME_ADDR(NAME_ADDR), .NAME_DATA(NAME_DATA),
    .PAT_ADDR(PAT_ADDR), .PAT_DATA(PAT_DATA),
    .PAL_WE(PAL_WE), .PAL_ADDR(PAL_ADDR), .PAL_DATA(PAL_DATA),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .DE(DE), .FRAME(FRAME)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // External RAMs with one cycle of read latency
  logic [11:0] name_m [2**NA_W];
  logic [15:0] pat_m  [2048];
  always @(posedge CLOCK) begin
    NAME_DATA <= name_m[NAME_ADDR];
    PAT_DATA  <= pat_m[PAT_ADDR];
  end

  logic [11:0] pal_m [64];
  logic [17:0] pw_q [$];

  int n_cmp = 0, n_bad = 0;
  int p;
  int pa_due, last_fr, de_cnt;
  logic [10:0] pa_exp;
  bit hs_prev, hs_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, p);
    end
  endtask

  function automatic logic [11:0] exp_rgb(input int hc, input int vc, input bit first);
    logic [11:0] nm;
    logic [15:0] pr;
    int b;
    if (hc >= H_VIS || vc >= V_VIS) return 12'h000;
    if (first && vc == 0 && hc < 8) return pal_m[0];
    nm = name_m[NA_W'((vc / 8) * HT + hc / 8)];
    pr = pat_m[{nm[7:0], 3'(vc % 8)}];
    b  = 7 - hc % 8;
    return pal_m[{nm[11:8], pr[8 + b], pr[b]}];
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'h0);
    check({tag, "_sync"}, 32'({VGA_HS, VGA_VS, DE, FRAME}), 32'b1100);
    check({tag, "_name_addr"}, 32'(NAME_ADDR), 32'h0);
    check({tag, "_pat_addr"}, 32'(PAT_ADDR), 32'h0);
  endtask

  // One pixel clock: predict the output for the current raster position, clock, compare.
  task automatic step();
    int hc, vc, fl, fc, fa;
    bit first, f_ok;
    logic [11:0] e_rgb;
    logic [3:0]  e_sync;
    hc    = p % H_TOTAL;
    vc    = (p / H_TOTAL) % V_TOTAL;
    first = (p < FRAME_CYC);
    e_rgb = exp_rgb(hc, vc, first);
    e_sync[3] = !(hc >= H_VIS + H_FP && hc < H_VIS + H_FP + H_SYNC);
    e_sync[2] = !(vc >= V_VIS + V_FP && vc < V_VIS + V_FP + V_SYNC);
    e_sync[1] = (hc < H_VIS) && (vc < V_VIS);
    e_sync[0] = (hc == 0) && (vc == 0);
    f_ok = 1'b0; fl = 0; fc = 0;
    if (hc == H_TOTAL - 8) begin
      fl = (vc + 1) % V_TOTAL; fc = 0; f_ok = 1'b1;
    end else if (hc % 8 == 0 && hc / 8 + 1 < HT) begin
      fl = vc; fc = hc / 8 + 1; f_ok = 1'b1;
    end
    if (fl >= V_VIS) f_ok = 1'b0;
    fa = ((fl / 8) * HT + fc) % (2**NA_W);
    @(posedge CLOCK);
    if (PAL_WE) pal_m[PAL_ADDR] = PAL_DATA;
    @(negedge CLOCK);
    PAL_WE = 1'b0;
    check("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e_rgb));
    check("sync", 32'({VGA_HS, VGA_VS, DE, FRAME}), 32'(e_sync));
    if (pa_due == p) check("pat_addr", 32'(PAT_ADDR), 32'(pa_exp));
    if (f_ok) begin
      check("name_addr", 32'(NAME_ADDR), 32'(fa));
      pa_due = p + 2;
      pa_exp = {name_m[NA_W'(fa)][7:0], 3'(fl % 8)};
    end
    if (!hs_seen && hs_prev && !VGA_HS) begin
      hs_seen = 1'b1;
      check("hs_first_fall", 32'(p + 1), 32'(H_VIS + H_FP + 1));
    end
    hs_prev = VGA_HS;
    if (FRAME) begin
      if (last_fr >= 0) check("frame_period", 32'(p + 1 - last_fr), 32'(FRAME_CYC));
      last_fr = p + 1;
    end
    if (first && vc == 1) begin
      de_cnt += int'(DE);
      if (hc == H_TOTAL - 1) check("de_per_line", 32'(de_cnt), 32'(H_VIS));
    end
    p++;
  endtask

  task automatic setup_frame(input int k);
    if (k == 1) begin
      for (int r = 0; r < 8; r++) pat_m[{8'd1, 3'(r)}] = 16'hAA55;
      pw_q.push_back({6'd1, 12'h00F});
      pw_q.push_back({6'd2, 12'h0F0});
    end else begin
      for (int i = 0; i < 2**NA_W; i++) name_m[i] = 12'($urandom);
      for (int i = 0; i < 2048; i++) pat_m[i] = 16'($urandom);
      if (k == 2) begin
        name_m[2**NA_W - 1] = {4'd3, 8'd7};
        for (int i = 0; i < 64; i++) pw_q.push_back({6'(i), 12'($urandom)});
      end
    end
  endtask

  task automatic drive_writes(input bit allow_random);
    logic [17:0] w;
    if (pw_q.size() > 0) begin
      w = pw_q.pop_front();
      PAL_WE = 1'b1; PAL_ADDR = w[17:12]; PAL_DATA = w[11:0];
    end else if (allow_random && $urandom_range(15) == 0) begin
      PAL_WE = 1'b1; PAL_ADDR = 6'($urandom); PAL_DATA = 12'($urandom);
    end
  endtask

  initial begin
    int hc, vc, fidx;
    RESET = 1'b1; PAL_WE = 1'b0; PAL_ADDR = '0; PAL_DATA = '0;
    p = 0; pa_due = -1; last_fr = -1; de_cnt = 0; pa_exp = '0;
    hs_prev = 1'b1; hs_seen = 1'b0;
    for (int i = 0; i < 64; i++) pal_m[i] = 12'h000;
    for (int i = 0; i < 2**NA_W; i++) name_m[i] = {4'd0, 8'd1};
    for (int i = 0; i < 2048; i++) pat_m[i] = 16'h0000;
    for (int r = 0; r < 8; r++) pat_m[{8'd1, 3'(r)}] = 16'h00FF;
    repeat (10) @(negedge CLOCK);
    check_reset("reset");
    RESET = 1'b0;
    pw_q.push_back({6'd1, 12'hF00});

    for (int n = 0; n < 3 * FRAME_CYC + 1500; n++) begin
      hc   = p % H_TOTAL;
      vc   = (p / H_TOTAL) % V_TOTAL;
      fidx = p / FRAME_CYC;
      if (hc == 0 && vc == V_VIS) setup_frame(fidx + 1);
      if (fidx == 0 && vc == 10 && hc == 30) pw_q.push_back({6'd1, 12'h0F0});
      drive_writes(fidx >= 2);
      step();
    end

    // Asynchronous reset mid-line for one cycle
    RESET = 1'b1;
    #1;
    check_reset("mid_reset");
    @(negedge CLOCK);
    RESET = 1'b0;
    pw_q.delete();
    for (int i = 0; i < 64; i++) pal_m[i] = 12'h000;
    p = 0; pa_due = -1; last_fr = -1; de_cnt = 0; hs_prev = 1'b1;
    for (int n = 0; n < FRAME_CYC + 500; n++) begin
      drive_writes(1'b1);
      step();
    end
    check("hs_fall_seen", 32'(hs_seen), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
